// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation controller driving one Montgomery multiplier.
// Optional leading-zero skip of the exponent scan: define MONT_EXP_SKIP_LZ_EN.
module mont_exp_ctrl #(
   parameter int unsigned N_WIDTH = 512,
   parameter int unsigned E_WIDTH = 512
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_WIDTH-1:0] in_x,
   input  logic [E_WIDTH-1:0] in_e,
   input  logic [N_WIDTH-1:0] in_m,
   input  logic [N_WIDTH-1:0] in_r,
   input  logic [N_WIDTH-1:0] in_r2,
   output logic [N_WIDTH-1:0] result,
   output logic               done,
   output logic               busy,
   output logic               mm_start,
   output logic [N_WIDTH-1:0] mm_a,
   output logic [N_WIDTH-1:0] mm_b,
   output logic [N_WIDTH-1:0] mm_m,
   input  logic [N_WIDTH-1:0] mm_result,
   input  logic               mm_done
);

   localparam int unsigned IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_TO_MONT, S_SCAN, S_SQ, S_MUL, S_NEXT, S_FROM_MONT, S_DONE
   } state_t;

   state_t             state_q, state_n;
   logic [N_WIDTH-1:0] acc_q, acc_n, xt_q, xt_n;
   logic [E_WIDTH-1:0] e_q, e_n;
   logic [IW-1:0]      idx_q, idx_n;
   logic               pend_q, pend_n;
   logic [N_WIDTH-1:0] result_n, mm_a_n, mm_b_n, mm_m_n;
   logic               done_n, busy_n, mm_start_n;

   // Multiplication issue request and end-of-bit step, resolved after the case
   logic               iss, step, mm_ack;
   state_t             iss_state;
   logic [N_WIDTH-1:0] iss_a, iss_b, step_acc;

   assign mm_ack = pend_q & mm_done;

   always_comb begin
      state_n    = state_q;
      acc_n      = acc_q;
      xt_n       = xt_q;
      e_n        = e_q;
      idx_n      = idx_q;
      pend_n     = pend_q;
      result_n   = result;
      mm_a_n     = mm_a;
      mm_b_n     = mm_b;
      mm_m_n     = mm_m;
      busy_n     = busy;
      done_n     = 1'b0;
      mm_start_n = 1'b0;
      iss        = 1'b0;
      iss_state  = S_IDLE;
      iss_a      = '0;
      iss_b      = '0;
      step       = 1'b0;
      step_acc   = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_n    = 1'b1;
               e_n       = in_e;
               acc_n     = in_r;
               idx_n     = IW'(E_WIDTH - 1);
               mm_m_n    = in_m;
               iss       = 1'b1;
               iss_state = S_TO_MONT;
               iss_a     = in_x;
               iss_b     = in_r2;
            end
         end
         S_TO_MONT: begin
            if (mm_ack) begin
               pend_n = 1'b0;
               xt_n   = mm_result;
`ifdef MONT_EXP_SKIP_LZ_EN
               state_n = S_SCAN;
`else
               iss       = 1'b1;
               iss_state = S_SQ;
               iss_a     = acc_q;
               iss_b     = acc_q;
`endif
            end
         end
`ifdef MONT_EXP_SKIP_LZ_EN
         // Walk down past leading zero bits, one bit per cycle
         S_SCAN: begin
            if (e_q[idx_q]) begin
               iss       = 1'b1;
               iss_state = S_SQ;
               iss_a     = acc_q;
               iss_b     = acc_q;
            end else if (idx_q == '0) begin
               iss       = 1'b1;
               iss_state = S_FROM_MONT;
               iss_a     = acc_q;
               iss_b     = N_WIDTH'(1);
            end else begin
               idx_n = idx_q - IW'(1);
            end
         end
`endif
         S_SQ: begin
            if (mm_ack) begin
               pend_n = 1'b0;
               acc_n  = mm_result;
               if (e_q[idx_q]) begin
                  iss       = 1'b1;
                  iss_state = S_MUL;
                  iss_a     = mm_result;
                  iss_b     = xt_q;
               end else begin
                  state_n = S_NEXT;
               end
            end
         end
         S_MUL: begin
            if (mm_ack) begin
               pend_n   = 1'b0;
               acc_n    = mm_result;
               step     = 1'b1;
               step_acc = mm_result;
            end
         end
         S_NEXT: step = 1'b1;
         S_FROM_MONT: begin
            if (mm_ack) begin
               pend_n   = 1'b0;
               result_n = mm_result;
               done_n   = 1'b1;
               state_n  = S_DONE;
            end
         end
         S_DONE: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // Last bit leaves the Montgomery domain, otherwise square for the next bit
      if (step) begin
         iss   = 1'b1;
         iss_a = step_acc;
         if (idx_q == '0) begin
            iss_state = S_FROM_MONT;
            iss_b     = N_WIDTH'(1);
         end else begin
            idx_n     = idx_q - IW'(1);
            iss_state = S_SQ;
            iss_b     = step_acc;
         end
      end

      if (iss) begin
         state_n    = iss_state;
         pend_n     = 1'b1;
         mm_start_n = 1'b1;
         mm_a_n     = iss_a;
         mm_b_n     = iss_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         xt_q     <= '0;
         e_q      <= '0;
         idx_q    <= '0;
         pend_q   <= 1'b0;
         result   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         mm_start <= 1'b0;
         mm_a     <= '0;
         mm_b     <= '0;
         mm_m     <= '0;
      end else begin
         state_q  <= state_n;
         acc_q    <= acc_n;
         xt_q     <= xt_n;
         e_q      <= e_n;
         idx_q    <= idx_n;
         pend_q   <= pend_n;
         result   <= result_n;
         done     <= done_n;
         busy     <= busy_n;
         mm_start <= mm_start_n;
         mm_a     <= mm_a_n;
         mm_b     <= mm_b_n;
         mm_m     <= mm_m_n;
      end
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: E_WIDTH=8 and E_WIDTH=512 instances, each with a behavioural
// Montgomery multiplier of random 1..20 cycle latency, checked against a plain modexp scoreboard.
module tb_mont_exp_ctrl;

   localparam int unsigned NW  = 512;
   localparam int unsigned EW  = 8;
   localparam int unsigned EWF = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   // E_WIDTH=8 instance
   logic          start8, done8, busy8, mm_start8, mm_done8, inj8;
   logic [EW-1:0] e8;
   logic [NW-1:0] x8, m8, r8, r28, result8, mm_a8, mm_b8, mm_m8, mm_res8;
   logic          mdl_done8 = 1'b0;
   logic          mbusy8 = 1'b0;
   int unsigned   lat8 = 0;
   assign mm_done8 = mdl_done8 | inj8;

   // E_WIDTH=512 instance
   logic           startf, donef, busyf, mm_startf, mm_donef;
   logic [EWF-1:0] ef;
   logic [NW-1:0]  xf, mf, rf, r2f, resultf, mm_af, mm_bf, mm_mf, mm_resf;
   logic           mbusyf = 1'b0;
   int unsigned    latf = 0;
   logic           mdl_donef = 1'b0;
   assign mm_donef = mdl_donef;

   mont_exp_ctrl #(.N_WIDTH(NW), .E_WIDTH(EW)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .in_x(x8), .in_e(e8), .in_m(m8),
      .in_r(r8), .in_r2(r28), .result(result8), .done(done8), .busy(busy8),
      .mm_start(mm_start8), .mm_a(mm_a8), .mm_b(mm_b8), .mm_m(mm_m8),
      .mm_result(mm_res8), .mm_done(mm_done8));

   mont_exp_ctrl #(.N_WIDTH(NW), .E_WIDTH(EWF)) u_dutf (
      .clk(clk), .reset(reset), .start(startf), .in_x(xf), .in_e(ef), .in_m(mf),
      .in_r(rf), .in_r2(r2f), .result(resultf), .done(donef), .busy(busyf),
      .mm_start(mm_startf), .mm_a(mm_af), .mm_b(mm_bf), .mm_m(mm_mf),
      .mm_result(mm_resf), .mm_done(mm_donef));

   // Bit-serial Montgomery product a*b*2^-512 mod m
   function automatic logic [NW-1:0] mont(input logic [NW-1:0] a, b, m);
      logic [NW+1:0] t;
      t = '0;
      for (int i = 0; i < int'(NW); i++) begin
         if (a[i]) t = t + {2'b0, b};
         if (t[0]) t = t + {2'b0, m};
         t = t >> 1;
      end
      if (t >= {2'b0, m}) t = t - {2'b0, m};
      return t[NW-1:0];
   endfunction

   function automatic logic [NW-1:0] modexp(input logic [NW-1:0] x, input logic [EWF-1:0] e,
                                            input logic [NW-1:0] m);
      logic [2*NW-1:0] r, mm, xx;
      mm = {{NW{1'b0}}, m};
      xx = {{NW{1'b0}}, x};
      r  = (2*NW)'(1) % mm;
      for (int i = int'(EWF) - 1; i >= 0; i--) begin
         r = (r * r) % mm;
         if (e[i]) r = (r * xx) % mm;
      end
      return r[NW-1:0];
   endfunction

   function automatic logic [NW-1:0] rmod(input logic [NW-1:0] m);
      logic [2*NW-1:0] t;
      t = (2*NW)'(1) << NW;
      t = t % {{NW{1'b0}}, m};
      return t[NW-1:0];
   endfunction

   function automatic logic [NW-1:0] r2mod(input logic [NW-1:0] m);
      logic [2*NW-1:0] t;
      t = {{NW{1'b0}}, rmod(m)};
      t = (t * t) % {{NW{1'b0}}, m};
      return t[NW-1:0];
   endfunction

   function automatic int exp_cnt(input logic [EWF-1:0] e, input int ew);
      int pop;
      pop = 0;
      for (int i = 0; i < ew; i++) if (e[i]) pop++;
`ifdef MONT_EXP_SKIP_LZ_EN
      begin
         int msb;
         msb = -1;
         for (int i = 0; i < ew; i++) if (e[i]) msb = i;
         if (pop == 0) return 2;
         return 2 + msb + 1 + pop;
      end
`else
      return 2 + ew + pop;
`endif
   endfunction

   function automatic logic [NW-1:0] rand512();
      logic [NW-1:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Behavioural multipliers; deliberately blind to reset so stale completions still arrive
   always @(posedge clk) begin
      mdl_done8 <= 1'b0;
      if (mm_start8) begin
         mm_res8 <= mont(mm_a8, mm_b8, mm_m8);
         lat8    <= $urandom_range(1, 20);
         mbusy8  <= 1'b1;
      end else if (mbusy8) begin
         if (lat8 <= 1) begin
            mdl_done8 <= 1'b1;
            mbusy8    <= 1'b0;
         end else lat8 <= lat8 - 1;
      end
   end

   always @(posedge clk) begin
      mdl_donef <= 1'b0;
      if (mm_startf) begin
         mm_resf <= mont(mm_af, mm_bf, mm_mf);
         latf    <= $urandom_range(1, 20);
         mbusyf  <= 1'b1;
      end else if (mbusyf) begin
         if (latf <= 1) begin
            mdl_donef <= 1'b1;
            mbusyf    <= 1'b0;
         end else latf <= latf - 1;
      end
   end

   task automatic chk(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   int            nst8 = 0, nd8 = 0, nstf = 0;
   logic          pend8 = 1'b0;
   logic [NW-1:0] cap_a, cap_b, cap_m;

   // One cycle of the 8-bit instance, tracking handshake rules at the sample point
   task automatic tick8();
      @(negedge clk);
      if (reset) pend8 = 1'b0;
      if (mm_done8 && pend8) begin
         chk("mm_a_stable", mm_a8, cap_a);
         chk("mm_b_stable", mm_b8, cap_b);
         chk("mm_m_stable", mm_m8, cap_m);
         pend8 = 1'b0;
      end
      if (mm_start8) begin
         chk("one_outstanding", NW'(pend8), NW'(0));
         pend8 = 1'b1;
         cap_a = mm_a8;
         cap_b = mm_b8;
         cap_m = mm_m8;
         nst8++;
      end
      if (done8) nd8++;
   endtask

   task automatic tickf();
      @(negedge clk);
      if (mm_startf) nstf++;
   endtask

   task automatic run8(input logic [NW-1:0] x, input logic [EW-1:0] e, input logic [NW-1:0] m,
                       input string tag, input int poke);
      logic [NW-1:0] exp_q[$];
      logic [NW-1:0] exp_r;
      int            s0, d0;
      exp_q.push_back(modexp(x, EWF'(e), m));
      x8 = x; e8 = e; m8 = m; r8 = rmod(m); r28 = r2mod(m);
      s0 = nst8; d0 = nd8;
      start8 = 1'b1;
      tick8();
      start8 = 1'b0;
      chk({tag, "_busy_k1"}, NW'(busy8), NW'(1));
      chk({tag, "_mm_start_k1"}, NW'(mm_start8), NW'(1));
      x8 = {16{32'hDEAD_BEEF}}; e8 = 8'h5A; m8 = NW'(1013); r8 = '1; r28 = '1;
      for (int c = 1; c < 3000 && !done8; c++) begin
         start8 = (poke != 0 && c == poke);
         tick8();
      end
      start8 = 1'b0;
      chk({tag, "_done_seen"}, NW'(done8), NW'(1));
      exp_r = exp_q.pop_front();
      chk({tag, "_result"}, result8, exp_r);
      chk({tag, "_busy_at_done"}, NW'(busy8), NW'(1));
      chk({tag, "_mm_count"}, NW'(nst8 - s0), NW'(exp_cnt(EWF'(e), EW)));
      tick8();
      chk({tag, "_done_pulse"}, NW'(done8), NW'(0));
      chk({tag, "_busy_drop"}, NW'(busy8), NW'(0));
      chk({tag, "_done_count"}, NW'(nd8 - d0), NW'(1));
      chk({tag, "_result_held"}, result8, exp_r);
   endtask

   task automatic runf(input logic [NW-1:0] x, input logic [EWF-1:0] e, input logic [NW-1:0] m,
                       input string tag);
      logic [NW-1:0] exp_q[$];
      int            s0;
      exp_q.push_back(modexp(x, e, m));
      xf = x; ef = e; mf = m; rf = rmod(m); r2f = r2mod(m);
      s0 = nstf;
      startf = 1'b1;
      tickf();
      startf = 1'b0;
      chk({tag, "_busy_k1"}, NW'(busyf), NW'(1));
      for (int c = 0; c < 30000 && !donef; c++) tickf();
      chk({tag, "_done_seen"}, NW'(donef), NW'(1));
      chk({tag, "_result"}, resultf, exp_q.pop_front());
      chk({tag, "_mm_count"}, NW'(nstf - s0), NW'(exp_cnt(e, EWF)));
      tickf();
      chk({tag, "_busy_drop"}, NW'(busyf), NW'(0));
   endtask

   initial begin
      logic [NW-1:0] fm, fx;
      int            s0, d0;
      reset = 1'b1; start8 = 1'b0; startf = 1'b0; inj8 = 1'b0;
      x8 = '0; e8 = '0; m8 = '0; r8 = '0; r28 = '0;
      xf = '0; ef = '0; mf = '0; rf = '0; r2f = '0;
      repeat (3) @(negedge clk);
      chk("rst_result", result8, '0);
      chk("rst_done", NW'(done8), NW'(0));
      chk("rst_busy", NW'(busy8), NW'(0));
      chk("rst_mm_start", NW'(mm_start8), NW'(0));
      chk("rst_mm_a", mm_a8, '0);
      chk("rst_mm_m", mm_m8, '0);
      chk("rst_busy_f", NW'(busyf), NW'(0));
      reset = 1'b0;
      tick8();

      run8(NW'(3), 8'd5, NW'(7), "basic", 0);
      chk("basic_is_5", result8, NW'(5));
      run8(NW'(3), 8'd0, NW'(7), "e_zero", 0);
      chk("e_zero_is_1", result8, NW'(1));
      run8(NW'(3), 8'd1, NW'(7), "e_one", 0);
      chk("e_one_is_3", result8, NW'(3));
      run8(NW'(0), 8'd0, NW'(1), "m_one", 0);
      run8(NW'(4), 8'hB7, NW'(1009), "busy_start", 30);

      // Reset in the middle of a run, then a stale and a stray multiplier completion
      x8 = NW'(5); e8 = 8'hFF; m8 = NW'(13); r8 = rmod(NW'(13)); r28 = r2mod(NW'(13));
      start8 = 1'b1;
      tick8();
      start8 = 1'b0;
      repeat (40) tick8();
      chk("pre_rst_busy", NW'(busy8), NW'(1));
      reset = 1'b1;
      tick8();
      chk("mid_rst_result", result8, '0);
      chk("mid_rst_done", NW'(done8), NW'(0));
      chk("mid_rst_busy", NW'(busy8), NW'(0));
      chk("mid_rst_mm_start", NW'(mm_start8), NW'(0));
      chk("mid_rst_mm_a", mm_a8, '0);
      chk("mid_rst_mm_b", mm_b8, '0);
      chk("mid_rst_mm_m", mm_m8, '0);
      reset = 1'b0;
      s0 = nst8; d0 = nd8;
      for (int c = 0; c < 25; c++) begin
         inj8 = (c == 10);
         tick8();
      end
      inj8 = 1'b0;
      chk("late_done_no_start", NW'(nst8 - s0), NW'(0));
      chk("late_done_no_done", NW'(nd8 - d0), NW'(0));
      chk("late_done_idle", NW'(busy8), NW'(0));
      chk("late_done_result", result8, '0);
      run8(NW'(2), 8'd10, NW'(1001), "after_reset", 0);
      chk("after_reset_is_23", result8, NW'(23));

      for (int k = 0; k < 4; k++) begin
         fm = rand512();
         fm[0] = 1'b1;
         fm[NW-1] = 1'b1;
         fx = rand512() % fm;
         runf(fx, rand512(), fm, "full_width");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
